// File: rtl/delay_timer_pro.sv
// Prescaled one-shot/periodic delay timer with abort, busy flag and remaining-count readback.
// Optional `DELAY_TIMER_RETRIGGER_EN: a trigger rising edge in one-shot COUNTING restarts the delay.
module delay_timer_pro #(
  parameter int WIDTH = 7,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] N,
  input  logic [PW-1:0]    presc,
  output logic             time_out,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             mode_q, mode_d;
  logic             time_out_q, busy_q;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] n_eff;
  logic             tick;

`ifdef DELAY_TIMER_RETRIGGER_EN
  logic trig_q;
  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trigger;
  end
`endif

  assign n_eff = (N == '0) ? WIDTH'(1) : N;
  assign tick  = (pre_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = COUNTING;
          count_d = n_eff;
          pre_d   = presc;
          mode_d  = mode;
        end
      end
      COUNTING, DONE: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (state_q == DONE && !mode_q) begin
          state_d = trigger ? WAIT_LOW : IDLE;
          count_d = '0;
        end else begin
          // Periodic DONE keeps counting: it is the first cycle of the next period.
          state_d = COUNTING;
          pre_d   = tick ? presc : pre_q - PW'(1);
          if (tick) begin
            if (count_q == WIDTH'(1)) begin
              state_d = DONE;
              count_d = n_eff;
              mode_d  = mode;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
`ifdef DELAY_TIMER_RETRIGGER_EN
          if (state_q == COUNTING && !mode_q && trigger && !trig_q) begin
            state_d = COUNTING;
            count_d = n_eff;
            pre_d   = presc;
          end
`endif
        end
      end
      WAIT_LOW: begin
        if (!trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pre_q       <= '0;
      mode_q      <= 1'b0;
      time_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pre_q       <= pre_d;
      mode_q      <= mode_d;
      time_out_q  <= (state_d == DONE);
      busy_q      <= (state_d == COUNTING) || (state_d == DONE);
      remaining_q <= ((state_d == COUNTING) || (state_d == DONE)) ? count_d : '0;
    end
  end

  assign time_out  = time_out_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_delay_timer_pro.sv
// Scoreboard bench for delay_timer_pro: expected pulse times are queued at trigger and matched by a pulse monitor.
module tb_delay_timer_pro;

  localparam int WIDTH = 7;
  localparam int PW    = 8;

  logic             clk = 1'b0;
  logic             rst, trigger, abort, mode;
  logic [WIDTH-1:0] N;
  logic [PW-1:0]    presc;
  logic             time_out, busy;
  logic [WIDTH-1:0] remaining;

  int n_checks = 0;
  int n_pass   = 0;
  int ec       = 0;
  int exp_q[$];

  delay_timer_pro #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .mode(mode),
    .N(N), .presc(presc), .time_out(time_out), .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  // Every pulse must match the head of the scoreboard, in edge-count time.
  always @(negedge clk) begin
    if (!rst && time_out) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse at edge %0d: got a pulse, required none", ec);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (ec !== e) $display("FAIL pulse_time got edge %0d required edge %0d", ec, e);
        else n_pass++;
      end
    end
  end

  function automatic int lat(input int n, input int p);
    return ((n == 0) ? 1 : n) * (p + 1);
  endfunction

  // Start a one-cycle trigger at the next edge and queue the pulse it should produce.
  task automatic fire(input int n, input int p, input logic m, input bit expect_pulse);
    @(negedge clk);
    N = WIDTH'(n); presc = PW'(p); mode = m; trigger = 1'b1;
    if (expect_pulse) exp_q.push_back(ec + 1 + lat(n, p));
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk); #1; k++;
    end
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() !== 0) begin
      $display("FAIL %s_drain got %0d pending pulses, required 0", name, exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic chk_idle(input string name);
    n_checks++;
    if ({busy, time_out, remaining} !== {2'b00, WIDTH'(0)})
      $display("FAIL %s busy=%0b time_out=%0b remaining=%0d required all 0", name, busy, time_out, remaining);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 1'b0; abort = 1'b0; mode = 1'b0; N = '0; presc = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");
  endtask

  task automatic test_basic();
    fire(5, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (remaining !== WIDTH'(5 - i) || busy !== 1'b1)
        $display("FAIL basic_remaining step %0d got %0d busy %0b required %0d busy 1", i, remaining, busy, 5 - i);
      else n_pass++;
      @(negedge clk);
    end
    drain("basic", 20);
    chk_idle("basic_end");
  endtask

  task automatic test_prescale();
    fire(4, 3, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (remaining !== WIDTH'(4 - k / 4))
        $display("FAIL prescale_remaining k=%0d got %0d required %0d", k, remaining, 4 - k / 4);
      else n_pass++;
      @(negedge clk);
    end
    drain("prescale", 20);
  endtask

  task automatic test_wait_low();
    @(negedge clk);
    N = 5; presc = 0; mode = 1'b0; trigger = 1'b1;
    exp_q.push_back(ec + 1 + 5);
    repeat (30) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() !== 0)
      $display("FAIL wait_low_hold busy=%0b pending=%0d required 0 and 0", busy, exp_q.size());
    else n_pass++;
    trigger = 1'b0;
    @(negedge clk);
    fire(5, 0, 1'b0, 1'b1);
    drain("wait_low", 20);
  endtask

  task automatic test_periodic_abort();
    int t0;
    @(negedge clk);
    t0 = ec;
    N = 3; presc = 1; mode = 1'b1; trigger = 1'b1;
    exp_q.push_back(t0 + 1 + 6);
    exp_q.push_back(t0 + 1 + 12);
    @(negedge clk);
    trigger = 1'b0;
    while (ec < t0 + 14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; mode = 1'b0;
    chk_idle("periodic_abort");
    drain("periodic", 30);
  endtask

  task automatic test_abort_terminal();
    int t0;
    t0 = ec;
    fire(2, 0, 1'b0, 1'b0);
    while (ec < t0 + 2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort_terminal");
    drain("abort_terminal", 10);
  endtask

  task automatic test_reset_mid();
    int t0;
    t0 = ec;
    fire(10, 0, 1'b0, 1'b0);
    while (ec < t0 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset_mid");
    drain("reset_mid_quiet", 15);
    fire(10, 0, 1'b0, 1'b1);
    drain("reset_mid_restart", 20);
  endtask

  task automatic test_n_zero();
    fire(0, 2, 1'b0, 1'b1);
    n_checks++;
    if (remaining !== WIDTH'(1))
      $display("FAIL n_zero_remaining got %0d required 1", remaining);
    else n_pass++;
    drain("n_zero", 10);
  endtask

  task automatic test_retrigger();
    int t0;
    @(negedge clk);
    t0 = ec;
    N = 6; presc = 0; mode = 1'b0; trigger = 1'b1;
`ifdef DELAY_TIMER_RETRIGGER_EN
    exp_q.push_back(t0 + 1 + 10);
`else
    exp_q.push_back(t0 + 1 + 6);
`endif
    @(negedge clk);
    trigger = 1'b0;
    while (ec < t0 + 4) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    drain("retrigger", 20);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      int n, p;
      n = $urandom_range(0, 12);
      p = $urandom_range(0, 3);
      fire(n, p, 1'b0, 1'b1);
      drain("back_to_back", lat(n, p) + 10);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_wait_low();
    test_periodic_abort();
    test_abort_terminal();
    test_reset_mid();
    test_n_zero();
    test_retrigger();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
